// File: rtl/mem_stage_if.sv
// Byte-wide shared memory port: the MEM stage is the master, the memory arbiter the slave.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_gnt;

  modport master (
    output mem_a,
    output mem_wr,
    output mem_dout,
    input  mem_din,
    input  mem_gnt
  );

  modport slave (
    input  mem_a,
    input  mem_wr,
    input  mem_dout,
    output mem_din,
    output mem_gnt
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: RV32I loads/stores serialised one byte per cycle over the
// shared little-endian memory port; stalls the pipeline while an access is in flight.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         mem_wd_i,
  input  logic               mem_wreg_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic [7:0]         mem_aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_reg2_i,
  output logic [4:0]         wb_wd,
  output logic               wb_wreg,
  output logic [31:0]        wb_wdata,
  output logic               stallreq_mem,
  mem_stage_if.master        mem_bus
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  cap_idx_q, cap_idx_d;
  logic [31:0] byte_buf_q, byte_buf_d;
  logic [31:0] addr_sum_s;
  logic [2:0]  n_bytes_s;
  logic        store_s;

  // Byte count of a memory op; zero marks a non-memory op.
  function automatic logic [2:0] op_bytes(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_bytes = 3'd1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_bytes = 3'd2;
      EXE_LW_OP, EXE_SW_OP:             op_bytes = 3'd4;
      default:                          op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: op_is_store = 1'b1;
      default:                         op_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [7:0] op, input logic [31:0] b);
    case (op)
      EXE_LB_OP:  load_result = {{24{b[7]}}, b[7:0]};
      EXE_LBU_OP: load_result = {24'd0, b[7:0]};
      EXE_LH_OP:  load_result = {{16{b[15]}}, b[15:0]};
      EXE_LHU_OP: load_result = {16'd0, b[15:0]};
      default:    load_result = b;
    endcase
  endfunction

  // State, counters and load byte buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= 3'd0;
      pend_q      <= 1'b0;
      cap_idx_q   <= 2'd0;
      byte_buf_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      pend_q      <= pend_d;
      cap_idx_q   <= cap_idx_d;
      byte_buf_q  <= byte_buf_d;
    end
  end

  // Next-state, byte sequencing and output decode; everything reads 0 during reset.
  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    pend_d           = 1'b0;
    cap_idx_d        = cap_idx_q;
    byte_buf_d       = byte_buf_q;
    wb_wd            = 5'd0;
    wb_wreg          = 1'b0;
    wb_wdata         = 32'd0;
    stallreq_mem     = 1'b0;
    mem_bus.mem_a    = '0;
    mem_bus.mem_wr   = 1'b0;
    mem_bus.mem_dout = 8'd0;
    addr_sum_s       = mem_addr_i + {29'd0, issue_cnt_q};
    n_bytes_s        = op_bytes(mem_aluop_i);
    store_s          = op_is_store(mem_aluop_i);

    if (rst) begin
      state_d = S_IDLE;
    end else begin
      // A read issued last cycle returns its byte now, whatever the grant does.
      if (pend_q) begin
        byte_buf_d[{cap_idx_q, 3'b000} +: 8] = mem_bus.mem_din;
      end else begin
        byte_buf_d = byte_buf_q;
      end

      case (state_q)
        S_IDLE: begin
          if (n_bytes_s != 3'd0) begin
            stallreq_mem = 1'b1;
            issue_cnt_d  = 3'd0;
            state_d      = S_ACCESS;
          end else begin
            wb_wd    = mem_wd_i;
            wb_wreg  = mem_wreg_i;
            wb_wdata = mem_wdata_i;
          end
        end
        S_ACCESS: begin
          stallreq_mem     = 1'b1;
          mem_bus.mem_a    = addr_sum_s[ADDR_W-1:0];
          mem_bus.mem_dout = store_s ? mem_reg2_i[{issue_cnt_q[1:0], 3'b000} +: 8] : 8'd0;
          if (mem_bus.mem_gnt) begin
            mem_bus.mem_wr = store_s;
            issue_cnt_d    = issue_cnt_q + 3'd1;
            pend_d         = ~store_s;
            cap_idx_d      = issue_cnt_q[1:0];
            if (issue_cnt_q + 3'd1 >= n_bytes_s) begin
              state_d = store_s ? S_DONE : S_WAIT;
            end else begin
              state_d = S_ACCESS;
            end
          end else begin
            mem_bus.mem_wr = 1'b0;
          end
        end
        S_WAIT: begin
          stallreq_mem = 1'b1;
          state_d      = S_DONE;
        end
        S_DONE: begin
          wb_wd       = mem_wd_i;
          wb_wreg     = mem_wreg_i;
          wb_wdata    = store_s ? mem_wdata_i : load_result(mem_aluop_i, byte_buf_q);
          issue_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule
